shift_add_mult_ctrl: RTL and testbench
======================================

// Module: shift_add_mult_ctrl
// PURPOSE
//   Sequencing controller for the shift-and-add multiplier datapath.
//   - Accepts an operand pair on a start handshake and holds multiplicand A stable.
//   - Scans multiplier B LSB-first and drives the accumulator's clear, bit-index and add-enable.
//   - Signals completion when the 2N-bit product in the accumulator is final.
//   - Sits directly upstream of the shift-accumulate register.
// PARAMETERS
//   N       8   operand width; legal 2..16 (acc_count is 4 bits)
// PORTS
//   clk        in   1    single clock, rising edge
//   rst        in   1    synchronous, active-high reset
//   start      in   1    request; accepted only in IDLE
//   a_in       in   N    multiplicand, sampled on accepted start
//   b_in       in   N    multiplier, sampled on accepted start
//   a_q        out  N    registered multiplicand to accumulator A input
//   acc_clr    out  1    accumulator clear, 1 cycle
//   acc_count  out  4    current bit index i (shift amount)
//   acc_en     out  1    accumulate A<<i this cycle
//   busy       out  1    high in CLEAR and RUN
//   done       out  1    1-cycle pulse, product valid in accumulator
// BEHAVIOUR
//   - Reset (sync, rst=1 at posedge): state=IDLE, a_q=0, b_q=0, count=0.
//     All outputs are 0 in the cycle after reset.
//   - Reset overrides everything, including mid-RUN; a half-built product is abandoned.
//   - States:
//     IDLE  -> CLEAR on start=1: latch a_in->a_q, b_in->b_q, count=0.
//     CLEAR -> RUN unconditionally; acc_clr=1 only here.
//     RUN   -> acc_en = b_q[count].
//              If count==N-1, go to DONE; else count<=count+1.
//     DONE  -> IDLE; done=1 only here.
//   - Outputs decode from registered state/count: acc_en, acc_clr, busy, done.
//     acc_count=count in all states.
//   - Timing, start accepted at edge 0:
//     cycle 1 CLEAR; cycles 2..N+1 RUN with count 0..N-1; cycle N+2 DONE.
//     Latency start->done = N+2 cycles.
//   - start while not in IDLE (incl. DONE) is ignored.
//     a_in/b_in changes after acceptance have no effect.
//   - start asserted continuously: a new operation begins in the cycle after DONE (IDLE accepts).
//   - a_q holds its value through DONE and IDLE until the next accepted start.
//   - count never exceeds N-1; no wrap-around occurs.
// CONFIGURATION
//   ZERO_SKIP_EN (macro) defined:
//     - In RUN, also go to DONE when b_q[N-1:count+1]==0 (no remaining 1 bits).
//     - Latency = 3 + index of highest set bit of B.
//     - B=0 gives a single RUN cycle with acc_en=0.
//   ZERO_SKIP_EN undefined:
//     - Fixed N+2 latency regardless of B.
// TESTING (N=8, controller driving the shift-accumulate register)
//   1. rst=1 for 2 cycles with start=1 -> all outputs 0; no CLEAR entered while rst=1.
//   2. A=0x0F, B=0xA5, start pulse -> acc_clr at cycle 1; acc_en 1,0,1,0,0,1,0,1 for count 0..7;
//      done at cycle 10; Q=0x09AB.
//   3. A=0xFF, B=0xFF -> acc_en high all 8 RUN cycles; Q=0xFE01 at done.
//   4. During RUN, start=1 with A=0x01, B=0x01 -> ignored; result is still the first product.
//   5. B=0x00, A=0x33 -> Q=0; done at cycle 10 without macro, cycle 3 with ZERO_SKIP_EN.
//      B=0x05 with ZERO_SKIP_EN -> done at cycle 5.
//   6. rst at count=3 mid-RUN -> next cycle IDLE, all outputs 0.
//      New start A=0x03, B=0x07 -> Q=0x0015.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// Sequencing controller for a shift-and-add multiplier: scans B LSB-first.
// Optional early termination on remaining zero bits: `define ZERO_SKIP_EN.
module shift_add_mult_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [N-1:0] a_q,
  output logic         acc_clr,
  output logic [3:0]   acc_count,
  output logic         acc_en,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0]   LAST = 4'(N - 1);
  localparam logic [N-1:0] ONE  = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   count_q, count_d;
  logic         rest_zero;

`ifdef ZERO_SKIP_EN
  // No set bits above the current index: the product is already final.
  assign rest_zero =
    (b_q >> ({1'b0, count_q} + 5'd1)) == '0;
`else
  assign rest_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          a_d     = a_in;
          b_d     = b_in;
          count_d = '0;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (count_q == LAST || rest_zero) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_clr   = (state_q == CLEAR);
  assign busy      = (state_q == CLEAR) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign acc_count = count_q;
  assign acc_en    = (state_q == RUN) &&
                     |(b_q & (ONE << count_q));

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a behavioural accumulator.
// Expected products and done cycles are hand-computed for N=8.
module tb_shift_add_mult_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [N-1:0] a_q;
  logic         acc_clr;
  logic [3:0]   acc_count;
  logic         acc_en;
  logic         busy;
  logic         done;

  logic [2*N-1:0] acc;

  int vecs = 0;
  int errs = 0;

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .a_q      (a_q),
    .acc_clr  (acc_clr),
    .acc_count(acc_count),
    .acc_en   (acc_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Downstream shift-accumulate register.
  always @(posedge clk) begin
    if (acc_clr)
      acc <= '0;
    else if (acc_en)
      acc <= acc + ({8'h00, a_q} << acc_count);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input int dn_def,
                        input int dn_skip,
                        input logic [15:0] q,
                        input bit intf);
    int clr_c;
    int done_c;
    int exp_dn;
    logic [7:0] mask;
`ifdef ZERO_SKIP_EN
    exp_dn = dn_skip;
`else
    exp_dn = dn_def;
`endif
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    clr_c  = 0;
    done_c = 0;
    mask   = '0;
    for (int c = 1; c <= 20; c++) begin
      if (acc_clr && clr_c == 0) clr_c = c;
      if (busy && !acc_clr)
        mask[acc_count[2:0]] = acc_en;
      if (done) begin
        done_c = c;
        break;
      end
      if (intf && c == 3) begin
        start = 1'b1;
        a_in  = 8'h01;
        b_in  = 8'h01;
      end
      tick();
    end
    chk({tag, "_clr"}, 32'(clr_c), 32'd1);
    chk({tag, "_en"}, 32'(mask), 32'(b));
    chk({tag, "_done"}, 32'(done_c), 32'(exp_dn));
    chk({tag, "_q"}, 32'(acc), 32'(q));
    chk({tag, "_aq"}, 32'(a_q), 32'(a));
    tick();
    chk({tag, "_idle"},
        {28'd0, busy, done, acc_clr, acc_en}, 32'd0);
    if (intf) begin
      tick();
      chk({tag, "_reacc"},
          {23'd0, acc_clr, a_q}, {23'd0, 1'b1, 8'h01});
      start = 1'b0;
      wait_done({tag, "_2nd"});
      chk({tag, "_2nd_q"}, 32'(acc), 32'd1);
      tick();
    end
  endtask

  initial begin
    bit hit;
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'hAA;
    b_in  = 8'h55;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_outs",
          {16'd0, busy, done, acc_clr, acc_en, acc_count, a_q},
          32'd0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_after_rst",
        {28'd0, busy, done, acc_clr, acc_en}, 32'd0);

    run_op("a5", 8'h0F, 8'hA5, 10, 10, 16'h09AB, 1'b0);
    run_op("ff", 8'hFF, 8'hFF, 10, 10, 16'hFE01, 1'b0);
    run_op("intf", 8'h12, 8'h34, 10, 8, 16'h03A8, 1'b1);
    run_op("b00", 8'h33, 8'h00, 10, 3, 16'h0000, 1'b0);
    run_op("b05", 8'h33, 8'h05, 10, 5, 16'h00FF, 1'b0);

    @(negedge clk);
    a_in  = 8'h0F;
    b_in  = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy && !acc_clr && acc_count == 4'd3) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_run_cnt3", 32'(hit), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_run_rst",
        {16'd0, busy, done, acc_clr, acc_en, acc_count, a_q},
        32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 8'h03, 8'h07, 10, 5, 16'h0015, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
